qoi_op_sched: RTL and testbench
===============================

Name: qoi_op_sched

Overview:
- Per-pixel controller for the QOI encoder datapath. Accepts RGBA pixels and tracks the previous pixel and the run length.
- Drives the 64-entry circular CAM: issues searches and writes it on misses.
- Selects one QOI chunk per pixel (RUN/INDEX/DIFF/LUMA/RGB/RGBA) and emits chunk bytes on a valid/ready stream to the byte packer.

Parameters:
- RUN_MAX, 62, run length at which a RUN chunk is forced out (1..62).
- IDX_BITS, 6, CAM index width; fixed to match the 64-entry CAM.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- pix_in  input  32  pixel {r[31:24],g[23:16],b[15:8],a[7:0]}
- pix_valid  input  1  pix_in valid
- pix_last  input  1  pix_in is the final pixel of the image
- pix_ready  output  1  block can accept a pixel this cycle
- cam_inp  output  24  CAM search/write data, {r,g,b}
- cam_rd_en  output  1  CAM search strobe
- cam_wr_en  output  1  CAM write strobe
- cam_index  input  IDX_BITS  CAM hit index (combinational)
- cam_index_valid  input  1  CAM hit (combinational)
- chunk_data  output  40  chunk bytes, first byte in [39:32], unused bytes zero
- chunk_len  output  3  valid byte count, 1..5
- chunk_valid  output  1  chunk present
- chunk_ready  input  1  downstream accepts chunk
- img_done  output  1  one-cycle pulse after the final chunk of an image is accepted

Behaviour:
- Reset (async, rst_n=0):
  - prev={0,0,0,255}, run=0, state=S_ACCEPT.
  - chunk_valid=0, chunk_data=0, chunk_len=0, img_done=0, cam_rd_en=0, cam_wr_en=0.
  - pix_ready=0 while rst_n=0.
  - Reset mid-image discards the pending chunk and run. CAM contents are not cleared.
- States:
  - S_ACCEPT: pix_ready=1 iff !chunk_valid || chunk_ready.
  - S_PIX: a RUN chunk is out; the pixel chunk is queued behind it. pix_ready=0.
  - S_FLUSH: a final RUN or pixel chunk is out. pix_ready=0.
- Accept = pix_valid && pix_ready. In the accept cycle:
  - cam_inp=pix_in[31:8] and cam_rd_en=1.
  - Hit/index and all deltas are sampled at this edge.
- Pixel equal to prev (all 32 bits):
  - run++.
  - If run reaches RUN_MAX, or pix_last: emit RUN {2'b11, run-1}, len 1, next cycle. Then run=0.
  - Otherwise no chunk.
- Pixel differs from prev:
  - If run>0: emit RUN first, then go to S_PIX with the pixel chunk held.
  - Otherwise emit the pixel chunk directly.
  - prev<=pix_in at accept.
- Pixel chunk priority, first match wins:
  - INDEX {2'b00, cam_index}, len 1, when cam_index_valid. Alpha is not part of the match.
  - DIFF {2'b01, dr+2, dg+2, db+2}, len 1, when da=0 and dr, dg, db are each in -2..1.
  - LUMA (see Optional Feature).
  - RGB {8'hFE, r, g, b}, len 4, when da=0.
  - RGBA {8'hFF, r, g, b, a}, len 5.
- Deltas: 8-bit two's-complement wrap, e.g. dr = (r - prev_r) mod 256 interpreted as signed.
- cam_wr_en=1 in the accept cycle iff the pixel differs from prev and there is no CAM hit. The CAM captures it at that edge.
- Output handshake:
  - chunk_* are registered and held stable while chunk_valid && !chunk_ready.
  - Latency from accept to chunk_valid is 1 cycle.
  - A new chunk may load in the same cycle the old one is taken.
- Image end:
  - pix_last on a differing pixel with run>0 produces RUN, then the pixel chunk.
  - img_done pulses the cycle after the last chunk's handshake.
  - prev is then reset to {0,0,0,255} and run=0.
- A run never exceeds RUN_MAX. Runs 63/64 are never emitted, since they collide with the RGB/RGBA tags.

Optional Feature:
- Macro: QOI_LUMA_EN.
- Defined: LUMA chunk, len 2, when da=0, dg in -32..31, and dr-dg and db-dg in -8..7. Checked after DIFF, before RGB.
  - Byte0 = {2'b10, dg+32}.
  - Byte1 = {dr-dg+8, db-dg+8}.
- Undefined: LUMA is never produced; those pixels fall through to RGB.

Test Plan:
- Reset, then pixel 0x000000FF ×3 with last on the 3rd -> single RUN 8'hC2, len 1, then img_done.
- Reset, then pixel 0x0A141EFF, then the same again -> chunk FE 0A 14 1E (len 4), then RUN C0. cam_wr_en=1 on the first pixel only.
- Reset, then pixels 0x11223380, 0x44556680, 0x11223380 -> RGBA, RGB, then INDEX {00, idx of first write}. No CAM write on the 3rd pixel.
- After prev 0x101010FF, pixel 0x0F1111FF -> DIFF 8'b01_01_11_11 = 8'h5F.
- 70 identical pixels after prev, chunk_ready held low for 5 cycles mid-stream -> RUN 8'hFD (62) then RUN 8'hC7 (8). chunk_data stable while stalled. pix_ready=0 during the stall.
- With QOI_LUMA_EN, prev 0x000000FF, pixel 0x0A0808FF -> LUMA 8'hA8 8'hA8. Without the macro -> FE 0A 08 08.

Source files
------------

// File: rtl/qoi_op_sched.sv
// qoi_op_sched: per-pixel chunk scheduler for the QOI encoder datapath.
// Tracks the previous pixel and the current run, drives the 64-entry CAM
// (search on every accepted pixel, write on a miss) and emits one QOI chunk
// per pixel on a registered valid/ready stream.
// Build option: define QOI_LUMA_EN to enable LUMA chunk generation; without
// it, LUMA-eligible pixels are coded as RGB.
module qoi_op_sched #(
    parameter int RUN_MAX  = 62,
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         pix_in,
    input  logic                pix_valid,
    input  logic                pix_last,
    output logic                pix_ready,
    output logic [23:0]         cam_inp,
    output logic                cam_rd_en,
    output logic                cam_wr_en,
    input  logic [IDX_BITS-1:0] cam_index,
    input  logic                cam_index_valid,
    output logic [39:0]         chunk_data,
    output logic [2:0]          chunk_len,
    output logic                chunk_valid,
    input  logic                chunk_ready,
    output logic                img_done
);

    typedef enum logic [1:0] {
        S_ACCEPT,
        S_PIX,
        S_FLUSH
    } state_t;

    localparam logic [31:0] PREV_INIT = 32'h000000FF;
    localparam logic [5:0]  RUN_LIM   = 6'(RUN_MAX);

    state_t state, state_nx;

    logic [31:0] prev;
    logic [5:0]  run;
    logic [39:0] pend_data;
    logic [2:0]  pend_len;
    logic        pend_last;

    logic        accept;
    logic        take;
    logic        same;
    logic        emit_same;
    logic [5:0]  run_inc;
    logic [39:0] pix_data;
    logic [2:0]  pix_len;

    logic signed [7:0] dr, dg, db, da;
    logic              diff_ok;

    // RUN chunk: tag 2'b11 with a biased run length, one byte.
    function automatic logic [39:0] run_chunk(input logic [5:0] code);
        return {2'b11, code, 32'h0};
    endfunction

`ifdef QOI_LUMA_EN
    logic signed [8:0] dr_dg, db_dg;
    logic              luma_ok;

    function automatic logic signed [8:0] sx9(input logic signed [7:0] v);
        return {v[7], v};
    endfunction

    assign dr_dg   = sx9(dr) - sx9(dg);
    assign db_dg   = sx9(db) - sx9(dg);
    assign luma_ok = (dg >= -8'sd32) && (dg <= 8'sd31) &&
                     (dr_dg >= -9'sd8) && (dr_dg <= 9'sd7) &&
                     (db_dg >= -9'sd8) && (db_dg <= 9'sd7);
`endif

    // Channel deltas wrap modulo 256 and are read as signed bytes.
    assign dr = pix_in[31:24] - prev[31:24];
    assign dg = pix_in[23:16] - prev[23:16];
    assign db = pix_in[15:8]  - prev[15:8];
    assign da = pix_in[7:0]   - prev[7:0];

    assign diff_ok = (dr >= -8'sd2) && (dr <= 8'sd1) &&
                     (dg >= -8'sd2) && (dg <= 8'sd1) &&
                     (db >= -8'sd2) && (db <= 8'sd1);

    // Pixels are only taken in S_ACCEPT when the output slot is free or draining.
    assign pix_ready = rst_n && (state == S_ACCEPT) && (!chunk_valid || chunk_ready);
    assign accept    = pix_valid && pix_ready;
    assign take      = chunk_valid && chunk_ready;
    assign same      = (pix_in == prev);
    assign run_inc   = run + 6'd1;
    assign emit_same = same && ((run_inc == RUN_LIM) || pix_last);

    // The CAM is searched with every accepted pixel and learns colours it missed.
    assign cam_inp   = pix_in[31:8];
    assign cam_rd_en = accept;
    assign cam_wr_en = accept && !same && !cam_index_valid;

    // Pixel chunk selection, highest priority first.
    always_comb begin
        pix_data = '0;
        pix_len  = '0;
        if (cam_index_valid) begin
            pix_data = {2'b00, cam_index, {(38 - IDX_BITS){1'b0}}};
            pix_len  = 3'd1;
        end else if ((da == 8'sd0) && diff_ok) begin
            pix_data = {2'b01, dr[1:0] + 2'd2, dg[1:0] + 2'd2, db[1:0] + 2'd2, 32'h0};
            pix_len  = 3'd1;
`ifdef QOI_LUMA_EN
        end else if ((da == 8'sd0) && luma_ok) begin
            pix_data = {2'b10, dg[5:0] + 6'd32, dr_dg[3:0] + 4'd8, db_dg[3:0] + 4'd8, 24'h0};
            pix_len  = 3'd2;
`endif
        end else if (da == 8'sd0) begin
            pix_data = {8'hFE, pix_in[31:8], 8'h00};
            pix_len  = 3'd4;
        end else begin
            pix_data = {8'hFF, pix_in};
            pix_len  = 3'd5;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_ACCEPT;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: a RUN ahead of a pixel chunk parks in S_PIX; the last chunk of an image waits in S_FLUSH.
    always_comb begin
        state_nx = state;
        case (state)
            S_ACCEPT: begin
                if (accept) begin
                    if (!same && (run != 6'd0)) begin
                        state_nx = S_PIX;
                    end else if (pix_last) begin
                        state_nx = S_FLUSH;
                    end
                end
            end
            S_PIX: begin
                if (take) begin
                    state_nx = pend_last ? S_FLUSH : S_ACCEPT;
                end
            end
            S_FLUSH: begin
                if (take) begin
                    state_nx = S_ACCEPT;
                end
            end
            default: state_nx = S_ACCEPT;
        endcase
    end

    // Pixel history, run counter, pending chunk and the registered output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev        <= PREV_INIT;
            run         <= '0;
            pend_data   <= '0;
            pend_len    <= '0;
            pend_last   <= 1'b0;
            chunk_data  <= '0;
            chunk_len   <= '0;
            chunk_valid <= 1'b0;
            img_done    <= 1'b0;
        end else begin
            img_done <= 1'b0;
            if (take) begin
                chunk_valid <= 1'b0;
            end
            case (state)
                S_ACCEPT: begin
                    if (accept && same) begin
                        if (emit_same) begin
                            chunk_data  <= run_chunk(run);
                            chunk_len   <= 3'd1;
                            chunk_valid <= 1'b1;
                            run         <= '0;
                        end else begin
                            run <= run_inc;
                        end
                    end else if (accept) begin
                        prev        <= pix_in;
                        run         <= '0;
                        chunk_valid <= 1'b1;
                        if (run != 6'd0) begin
                            chunk_data <= run_chunk(run - 6'd1);
                            chunk_len  <= 3'd1;
                            pend_data  <= pix_data;
                            pend_len   <= pix_len;
                            pend_last  <= pix_last;
                        end else begin
                            chunk_data <= pix_data;
                            chunk_len  <= pix_len;
                        end
                    end
                end
                S_PIX: begin
                    if (take) begin
                        chunk_data  <= pend_data;
                        chunk_len   <= pend_len;
                        chunk_valid <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (take) begin
                        img_done <= 1'b1;
                        prev     <= PREV_INIT;
                        run      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qoi_op_sched.sv
// Self-checking bench for qoi_op_sched: directed scenarios plus a randomized
// image stream, scored against a chunk-level QOI reference model.
module tb_qoi_op_sched;

    localparam int          RUN_MAX   = 62;
    localparam logic [31:0] PREV_INIT = 32'h000000FF;

    typedef struct packed {
        logic [39:0] data;
        logic [2:0]  len;
    } chunk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_last = 1'b0;
    logic        pix_ready;
    logic [23:0] cam_inp;
    logic        cam_rd_en;
    logic        cam_wr_en;
    logic [5:0]  cam_index;
    logic        cam_index_valid;
    logic [39:0] chunk_data;
    logic [2:0]  chunk_len;
    logic        chunk_valid;
    logic        chunk_ready = 1'b1;
    logic        img_done;

    int n_checks = 0;
    int n_pass   = 0;
    int rdy_mode = 0;

    always #5 clk = ~clk;

    qoi_op_sched #(.RUN_MAX(RUN_MAX), .IDX_BITS(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
        .cam_inp(cam_inp), .cam_rd_en(cam_rd_en), .cam_wr_en(cam_wr_en),
        .cam_index(cam_index), .cam_index_valid(cam_index_valid),
        .chunk_data(chunk_data), .chunk_len(chunk_len), .chunk_valid(chunk_valid),
        .chunk_ready(chunk_ready), .img_done(img_done)
    );

    // Environment CAM: 64 entries written round-robin, combinational search.
    logic [23:0] cam_mem [64];
    logic        cam_vld [64];
    logic [5:0]  cam_wptr;

    initial begin
        for (int i = 0; i < 64; i++) begin
            cam_mem[i] = '0;
            cam_vld[i] = 1'b0;
        end
        cam_wptr = '0;
    end

    always @(posedge clk) begin
        if (cam_wr_en) begin
            cam_mem[cam_wptr] <= cam_inp;
            cam_vld[cam_wptr] <= 1'b1;
            cam_wptr          <= cam_wptr + 6'd1;
        end
    end

    always_comb begin
        cam_index_valid = 1'b0;
        cam_index       = '0;
        for (int i = 0; i < 64; i++) begin
            if (cam_rd_en && cam_vld[i] && cam_mem[i] == cam_inp) begin
                cam_index_valid = 1'b1;
                cam_index       = 6'(i);
            end
        end
    end

    // Reference model state: previous pixel, run, and every colour ever written to the CAM.
    logic [31:0] m_prev = PREV_INIT;
    int          m_run = 0;
    logic [23:0] m_hist[$];
    chunk_t      exp_q[$];
    logic [42:0] got_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int wrap8(input int v);
        return ((v + 384) % 256) - 128;
    endfunction

    function automatic logic [7:0] add8(input logic [7:0] c, input int d);
        return 8'(int'(c) + d);
    endfunction

    function automatic chunk_t run_c(input int n);
        chunk_t c;
        c.data = {8'(192 + n - 1), 32'h0};
        c.len  = 3'd1;
        return c;
    endfunction

    function automatic chunk_t pixel_chunk(input logic [31:0] p, input logic [31:0] q,
                                           input logic hit, input int idx);
        chunk_t c;
        int dr, dg, db, da;
        dr = wrap8(int'(p[31:24]) - int'(q[31:24]));
        dg = wrap8(int'(p[23:16]) - int'(q[23:16]));
        db = wrap8(int'(p[15:8])  - int'(q[15:8]));
        da = wrap8(int'(p[7:0])   - int'(q[7:0]));
        if (hit) begin
            c.data = {8'(idx), 32'h0};
            c.len  = 3'd1;
        end else if (da == 0 && dr >= -2 && dr <= 1 && dg >= -2 && dg <= 1 && db >= -2 && db <= 1) begin
            c.data = {8'(64 + (dr + 2) * 16 + (dg + 2) * 4 + (db + 2)), 32'h0};
            c.len  = 3'd1;
`ifdef QOI_LUMA_EN
        end else if (da == 0 && dg >= -32 && dg <= 31 && dr - dg >= -8 && dr - dg <= 7 &&
                     db - dg >= -8 && db - dg <= 7) begin
            c.data = {8'(128 + dg + 32), 8'((dr - dg + 8) * 16 + (db - dg + 8)), 24'h0};
            c.len  = 3'd2;
`endif
        end else if (da == 0) begin
            c.data = {8'hFE, p[31:8], 8'h00};
            c.len  = 3'd4;
        end else begin
            c.data = {8'hFF, p};
            c.len  = 3'd5;
        end
        return c;
    endfunction

    // Apply one accepted pixel to the model; returns whether a CAM write is due.
    task automatic model_accept(input logic [31:0] p, input logic last, output logic exp_wr);
        logic   hit;
        int     idx;
        int     n;
        chunk_t done_c;
        exp_wr = 1'b0;
        if (p == m_prev) begin
            m_run++;
            if (m_run == RUN_MAX || last) begin
                exp_q.push_back(run_c(m_run));
                m_run = 0;
            end
        end else begin
            hit = 1'b0;
            idx = 0;
            n   = m_hist.size();
            for (int k = n - 1; k >= 0 && k >= n - 64; k--) begin
                if (!hit && m_hist[k] == p[31:8]) begin
                    hit = 1'b1;
                    idx = k % 64;
                end
            end
            exp_wr = !hit;
            if (m_run > 0) exp_q.push_back(run_c(m_run));
            m_run = 0;
            exp_q.push_back(pixel_chunk(p, m_prev, hit, idx));
            if (!hit) m_hist.push_back(p[31:8]);
            m_prev = p;
        end
        if (last) begin
            done_c = '0;
            exp_q.push_back(done_c);
            m_prev = PREV_INIT;
            m_run  = 0;
        end
    endtask

    task automatic send(input logic [31:0] p, input logic last);
        logic exp_wr;
        logic taken;
        int   waited;
        taken  = 1'b0;
        waited = 0;
        pix_in    = p;
        pix_last  = last;
        pix_valid = 1'b1;
        while (!taken && waited <= 2000) begin
            #1;
            if (pix_ready) begin
                model_accept(p, last, exp_wr);
                check("cam_rd_en", 64'(cam_rd_en), 64'd1);
                check("cam_inp", 64'(cam_inp), 64'(p[31:8]));
                check("cam_wr_en", 64'(cam_wr_en), 64'(exp_wr));
                taken = 1'b1;
            end else begin
                waited++;
            end
            @(negedge clk);
        end
        if (!taken) begin
            n_checks++;
            $display("FAIL pix_ready_timeout: waited %0d cycles, expected acceptance", waited);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic do_reset();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_pix_ready", 64'(pix_ready), 64'd0);
        check("rst_chunk_valid", 64'(chunk_valid), 64'd0);
        check("rst_chunk_data", 64'(chunk_data), 64'd0);
        check("rst_chunk_len", 64'(chunk_len), 64'd0);
        check("rst_img_done", 64'(img_done), 64'd0);
        check("rst_cam_rd_en", 64'(cam_rd_en), 64'd0);
        check("rst_cam_wr_en", 64'(cam_wr_en), 64'd0);
        m_prev = PREV_INIT;
        m_run  = 0;
        exp_q.delete();
        got_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic expect_got(input string name, input int idx, input logic [39:0] d, input logic [2:0] l);
        logic [42:0] a;
        a = '1;
        if (idx < got_q.size()) a = got_q[idx];
        check(name, 64'(a), 64'({d, l}));
    endtask

    // Downstream ready: always, random, or held low.
    initial begin
        forever begin
            @(negedge clk);
            if (rdy_mode == 2) chunk_ready = 1'b0;
            else if (rdy_mode == 1) chunk_ready = ($urandom_range(0, 99) < 65);
            else chunk_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each chunk handshake and each img_done pulse.
    initial begin
        chunk_t      e;
        logic        was_stall;
        logic [42:0] held;
        was_stall = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                was_stall = 1'b0;
            end else begin
                if (was_stall)
                    check("hold_stable", 64'({chunk_valid, chunk_data, chunk_len}), 64'({1'b1, held}));
                if (chunk_valid && !chunk_ready)
                    check("pix_ready_in_stall", 64'(pix_ready), 64'd0);
                if (img_done) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL img_done: unexpected pulse, expected no pending item");
                    end else begin
                        e = exp_q.pop_front();
                        check("img_done_position", 64'({e.data, e.len}), 64'd0);
                    end
                    got_q.push_back('0);
                end
                if (chunk_valid && chunk_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL chunk: unexpected %h len %0d, expected nothing", chunk_data, chunk_len);
                    end else begin
                        e = exp_q.pop_front();
                        check("chunk", 64'({chunk_data, chunk_len}), 64'({e.data, e.len}));
                    end
                    got_q.push_back({chunk_data, chunk_len});
                end
                was_stall = chunk_valid && !chunk_ready;
                held      = {chunk_data, chunk_len};
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Run of three ending the image.
        do_reset();
        for (int i = 0; i < 3; i++) send(32'h000000FF, i == 2);
        drain();
        expect_got("t1_run", 0, 40'hC200000000, 3'd1);
        expect_got("t1_done", 1, 40'h0, 3'd0);

        // RGB then a run of one.
        do_reset();
        send(32'h0A141EFF, 1'b0);
        send(32'h0A141EFF, 1'b1);
        drain();
        expect_got("t2_rgb", 0, 40'hFE0A141E00, 3'd4);
        expect_got("t2_run", 1, 40'hC000000000, 3'd1);

        // RGBA, RGB, then INDEX of the first colour written in this test (CAM slot 1).
        do_reset();
        send(32'h11223380, 1'b0);
        send(32'h44556680, 1'b0);
        send(32'h11223380, 1'b1);
        drain();
        expect_got("t3_rgba", 0, 40'hFF11223380, 3'd5);
        expect_got("t3_rgb", 1, 40'hFE44556600, 3'd4);
        expect_got("t3_index", 2, 40'h0100000000, 3'd1);

        // DIFF.
        do_reset();
        send(32'h101010FF, 1'b0);
        send(32'h0F1111FF, 1'b1);
        drain();
        expect_got("t4_diff", 1, 40'h5F00000000, 3'd1);

        // 70 repeats with a 5-cycle stall on the forced RUN_MAX chunk.
        do_reset();
        for (int i = 0; i < 61; i++) send(32'h000000FF, 1'b0);
        rdy_mode = 2;
        send(32'h000000FF, 1'b0);
        repeat (5) begin
            #2;
            check("t5_stall_valid", 64'(chunk_valid), 64'd1);
            check("t5_stall_data", 64'(chunk_data), 64'hFD00000000);
            check("t5_stall_ready", 64'(pix_ready), 64'd0);
            @(negedge clk);
        end
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) send(32'h000000FF, i == 7);
        drain();
        expect_got("t5_run62", 0, 40'hFD00000000, 3'd1);
        expect_got("t5_run8", 1, 40'hC700000000, 3'd1);

        // LUMA-eligible pixel.
        do_reset();
        send(32'h0A0808FF, 1'b1);
        drain();
`ifdef QOI_LUMA_EN
        expect_got("t6_luma", 0, 40'hA8A8000000, 3'd2);
`else
        expect_got("t6_rgb", 0, 40'hFE0A080800, 3'd4);
`endif

        // Reset mid-run discards the run.
        do_reset();
        for (int i = 0; i < 3; i++) send(32'h000000FF, 1'b0);
        do_reset();
        send(32'h000000FF, 1'b1);
        drain();
        expect_got("t7_run_after_reset", 0, 40'hC000000000, 3'd1);

        // Randomized images with random backpressure.
        do_reset();
        rdy_mode = 1;
        begin
            logic [31:0] pal [16];
            for (int i = 0; i < 16; i++) pal[i] = {$urandom_range(0, 255) == 0 ? 24'h0 : 24'($urandom), ($urandom_range(0, 3) == 0) ? 8'h80 : 8'hFF};
            for (int i = 0; i < 1500; i++) begin
                int          sel;
                int          d;
                logic [31:0] p;
                logic        last;
                sel = $urandom_range(0, 99);
                d   = int'($urandom_range(0, 63)) - 32;
                if (sel < 35) p = m_prev;
                else if (sel < 55) p = pal[$urandom_range(0, 15)];
                else if (sel < 75) p = {add8(m_prev[31:24], int'($urandom_range(0, 3)) - 2),
                                        add8(m_prev[23:16], int'($urandom_range(0, 3)) - 2),
                                        add8(m_prev[15:8],  int'($urandom_range(0, 3)) - 2), m_prev[7:0]};
                else if (sel < 88) p = {add8(m_prev[31:24], d + int'($urandom_range(0, 15)) - 8),
                                        add8(m_prev[23:16], d),
                                        add8(m_prev[15:8],  d + int'($urandom_range(0, 15)) - 8), m_prev[7:0]};
                else if (sel < 95) p = {m_prev[31:8], 8'($urandom)};
                else p = $urandom;
                if ($urandom_range(0, 99) < 2) begin
                    for (int k = 0; k < 70; k++) send(m_prev, 1'b0);
                end
                last = ($urandom_range(0, 99) < 3) || (i == 1499);
                if ($urandom_range(0, 9) == 0) @(negedge clk);
                send(p, last);
            end
        end
        drain();
        rdy_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
